// File: rtl/pll_clk_seq.sv
// PLL output-clock enable sequencer: filters LOCK, staggers ENCLK0..4, holds sys_rst, then runs.
// Any loss of lock after sequencing starts tears everything down and replays from the lock filter.
module pll_clk_seq #(
  parameter int unsigned LOCK_FILT = 1024,
  parameter int unsigned STAGE_GAP = 16,
  parameter int unsigned RST_HOLD  = 64
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic [4:0] en_mask,
  output logic [4:0] enclk,
  output logic       sys_rst,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] relock_cnt
);

  typedef enum logic [2:0] {
    StWaitLock,
    StFilter,
    StEnable,
    StHoldRst,
    StRun
  } state_e;

  localparam logic [15:0] FiltLast = 16'(LOCK_FILT - 1);
  localparam logic [7:0]  GapLast  = 8'(STAGE_GAP - 1);
  localparam logic [15:0] HoldLast = 16'(RST_HOLD - 1);

  state_e      state_q, state_d;
  logic        sync1_q, lock_s_q;
  logic [15:0] filt_q, filt_d;
  logic [7:0]  gap_q, gap_d;
  logic [15:0] hold_q, hold_d;
  logic [4:0]  stage_q, stage_d;
  logic [4:0]  enclk_q, enclk_d;
  logic        sys_rst_q, sys_rst_d;
  logic        ready_q, ready_d;
  logic        lock_lost_q, lock_lost_d;
  logic [7:0]  relock_q, relock_d;

  always_comb begin
    state_d     = state_q;
    filt_d      = filt_q;
    gap_d       = gap_q;
    hold_d      = hold_q;
    stage_d     = stage_q;
    sys_rst_d   = sys_rst_q;
    ready_d     = ready_q;
    lock_lost_d = 1'b0;
    relock_d    = relock_q;

    unique case (state_q)
      StWaitLock: begin
        filt_d    = '0;
        gap_d     = '0;
        hold_d    = '0;
        stage_d   = '0;
        sys_rst_d = 1'b1;
        ready_d   = 1'b0;
        if (lock_s_q) state_d = StFilter;
      end
      StFilter: begin
        if (!lock_s_q) begin
          state_d = StWaitLock;
          filt_d  = '0;
        end else if (filt_q == FiltLast) begin
          state_d = StEnable;
          stage_d = 5'b00001;
          gap_d   = '0;
        end else begin
          filt_d = filt_q + 16'd1;
        end
      end
      StEnable: begin
        if (lock_s_q) begin
          if (gap_q == GapLast) begin
            gap_d   = '0;
            stage_d = {stage_q[3:0], 1'b1};
            if (stage_q[3]) begin
              state_d = StHoldRst;
              hold_d  = '0;
            end
          end else begin
            gap_d = gap_q + 8'd1;
          end
        end
      end
      StHoldRst: begin
        if (lock_s_q) begin
          if (hold_q == HoldLast) begin
            state_d   = StRun;
            sys_rst_d = 1'b0;
            ready_d   = 1'b1;
          end else begin
            hold_d = hold_q + 16'd1;
          end
        end
      end
      StRun: ;
      default: state_d = StWaitLock;
    endcase

    // Lock loss once sequencing has begun: tear down and count the event.
    if (!lock_s_q && (state_q == StEnable || state_q == StHoldRst || state_q == StRun)) begin
      state_d     = StWaitLock;
      filt_d      = '0;
      gap_d       = '0;
      hold_d      = '0;
      stage_d     = '0;
      sys_rst_d   = 1'b1;
      ready_d     = 1'b0;
      lock_lost_d = 1'b1;
      if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
    end

    enclk_d = stage_d & en_mask;
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= StWaitLock;
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      filt_q      <= '0;
      gap_q       <= '0;
      hold_q      <= '0;
      stage_q     <= '0;
      enclk_q     <= '0;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      relock_q    <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= pll_lock;
      lock_s_q    <= sync1_q;
      filt_q      <= filt_d;
      gap_q       <= gap_d;
      hold_q      <= hold_d;
      stage_q     <= stage_d;
      enclk_q     <= enclk_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      relock_q    <= relock_d;
    end
  end

  assign enclk      = enclk_q;
  assign sys_rst    = sys_rst_q;
  assign ready      = ready_q;
  assign lock_lost  = lock_lost_q;
  assign relock_cnt = relock_q;

endmodule

// File: tb/tb_pll_clk_seq.sv
// Directed bench for pll_clk_seq with LOCK_FILT=8, STAGE_GAP=4, RST_HOLD=6.
// Cycle n means "sampled 1 time unit after the n-th rising edge following the cycle-0 marker".
module tb_pll_clk_seq;

  logic       clkin = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic [4:0] en_mask;
  logic [4:0] enclk;
  logic       sys_rst;
  logic       ready;
  logic       lock_lost;
  logic [7:0] relock_cnt;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  pll_clk_seq #(
    .LOCK_FILT(8),
    .STAGE_GAP(4),
    .RST_HOLD (6)
  ) dut (
    .clkin     (clkin),
    .reset     (reset),
    .pll_lock  (pll_lock),
    .en_mask   (en_mask),
    .enclk     (enclk),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .lock_lost (lock_lost),
    .relock_cnt(relock_cnt)
  );

  always #5 clkin = ~clkin;

  task automatic tick(input int n);
    repeat (n) @(posedge clkin);
    #1;
    cyc += n;
  endtask

  task automatic goto(input int c);
    tick(c - cyc);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [4:0] e_enclk, input logic e_rst,
                         input logic e_rdy, input logic e_lost, input logic [7:0] e_cnt);
    chk({tag, ".enclk"}, 32'(enclk), 32'(e_enclk));
    chk({tag, ".sys_rst"}, 32'(sys_rst), 32'(e_rst));
    chk({tag, ".ready"}, 32'(ready), 32'(e_rdy));
    chk({tag, ".lock_lost"}, 32'(lock_lost), 32'(e_lost));
    chk({tag, ".relock_cnt"}, 32'(relock_cnt), 32'(e_cnt));
  endtask

  int exp_cnt;
  int pulses;

  initial begin
    reset    = 1'b1;
    pll_lock = 1'b0;
    en_mask  = 5'b11111;
    tick(3);
    chk_out("reset", 5'b00000, 1'b1, 1'b0, 1'b0, 8'd0);

    // Full sequence from a stable lock.
    reset    = 1'b0;
    pll_lock = 1'b1;
    cyc      = 0;
    goto(10); chk_out("seq.c10", 5'b00000, 1'b1, 1'b0, 1'b0, 8'd0);
    goto(11); chk_out("seq.c11", 5'b00001, 1'b1, 1'b0, 1'b0, 8'd0);
    goto(14); chk("seq.c14", 32'(enclk), 32'h01);
    goto(15); chk("seq.c15", 32'(enclk), 32'h03);
    goto(19); chk("seq.c19", 32'(enclk), 32'h07);
    goto(23); chk("seq.c23", 32'(enclk), 32'h0F);
    goto(27); chk_out("seq.c27", 5'b11111, 1'b1, 1'b0, 1'b0, 8'd0);
    goto(32); chk_out("seq.c32", 5'b11111, 1'b1, 1'b0, 1'b0, 8'd0);
    goto(33); chk_out("seq.c33", 5'b11111, 1'b0, 1'b1, 1'b0, 8'd0);
    goto(40); chk_out("run.c40", 5'b11111, 1'b0, 1'b1, 1'b0, 8'd0);

    // Lock loss in RUN.
    pll_lock = 1'b0;
    cyc      = 0;
    goto(2); chk_out("loss.c2", 5'b11111, 1'b0, 1'b1, 1'b0, 8'd0);
    goto(3); chk_out("loss.c3", 5'b00000, 1'b1, 1'b0, 1'b1, 8'd1);
    goto(4); chk_out("loss.c4", 5'b00000, 1'b1, 1'b0, 1'b0, 8'd1);

    // Relock replays the timing; reset lands at cycle 20.
    pll_lock = 1'b1;
    cyc      = 0;
    goto(10); chk("relock.c10", 32'(enclk), 32'h00);
    goto(11); chk("relock.c11", 32'(enclk), 32'h01);
    goto(15); chk("relock.c15", 32'(enclk), 32'h03);
    goto(19); chk("relock.c19", 32'(enclk), 32'h07);
    reset = 1'b1;
    goto(20); chk_out("midrst.c20", 5'b00000, 1'b1, 1'b0, 1'b0, 8'd0);
    reset   = 1'b0;
    en_mask = 5'b10101;
    cyc     = 0;
    goto(10); chk_out("postrst.c10", 5'b00000, 1'b1, 1'b0, 1'b0, 8'd0);
    goto(11); chk("mask.c11", 32'(enclk), 32'h01);
    goto(15); chk("mask.c15", 32'(enclk), 32'h01);
    goto(19); chk("mask.c19", 32'(enclk), 32'h05);
    goto(23); chk("mask.c23", 32'(enclk), 32'h05);
    goto(27); chk_out("mask.c27", 5'b10101, 1'b1, 1'b0, 1'b0, 8'd0);
    goto(32); chk("mask.c32", 32'(sys_rst), 32'h1);
    goto(33); chk_out("mask.c33", 5'b10101, 1'b0, 1'b1, 1'b0, 8'd0);
    en_mask = 5'b11111;
    goto(34); chk("mask.live", 32'(enclk), 32'h1F);

    // Drop lock, then a 5-cycle glitch must never start sequencing.
    pll_lock = 1'b0;
    cyc      = 0;
    goto(3); chk_out("loss2.c3", 5'b00000, 1'b1, 1'b0, 1'b1, 8'd1);
    goto(6);
    pll_lock = 1'b1;
    cyc      = 0;
    goto(5);
    pll_lock = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk_out("glitch", 5'b00000, 1'b1, 1'b0, 1'b0, 8'd1);
    end
    pll_lock = 1'b1;
    cyc      = 0;
    goto(10); chk("stable.c10", 32'(enclk), 32'h00);
    goto(11); chk("stable.c11", 32'(enclk), 32'h01);
    goto(27); chk("stable.c27", 32'(enclk), 32'h1F);
    goto(33); chk_out("stable.c33", 5'b11111, 1'b0, 1'b1, 1'b0, 8'd1);

    // 300 forced losses during ENABLE; counter saturates at 255.
    exp_cnt = 1;
    pulses  = 0;
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b0;
      tick(2);
      if (lock_lost) pulses++;
      tick(1);
      if (lock_lost) pulses++;
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      chk("sat.cnt", 32'(relock_cnt), 32'(exp_cnt));
      tick(1);
      if (lock_lost) pulses++;
      pll_lock = 1'b1;
      tick(11);
    end
    chk("sat.pulses", 32'(pulses), 32'd300);
    chk("sat.final", 32'(relock_cnt), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
